load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  MEM-stage load/store unit; sits directly upstream of the word-wide data memory.
//  Turns one byte/half/word load or store request from EX into memory port
//  activity, extracts and extends load data, and checks alignment and range.
//  The memory only writes whole words, so SB/SH run as a 2-cycle read-modify-write.
//  Big-endian byte order: byte offset 0 is bits [31:24].
// PARAMETERS
//  ADDR_W       16   width of mem_addr (memory word index)
//  DEPTH_WORDS  128  implemented words; a word index >= DEPTH_WORDS is a range error
// PORTS
//  clk          in   1       clock, all state updates on posedge
//  rst_n        in   1       synchronous active-low reset
//  req_valid    in   1       request present
//  req_ready    out  1       unit can accept (high only in IDLE)
//  req_we       in   1       1 = store, 0 = load
//  req_size     in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_uns      in   1       load zero-extends (LBU/LHU); ignored for stores and words
//  req_addr     in   32      byte address
//  req_wdata    in   32      store data, right-justified (byte in [7:0], half in [15:0])
//  resp_valid   out  1       one-cycle completion pulse
//  resp_rdata   out  32      extended load data, valid with resp_valid; 0 for stores/errors
//  resp_err     out  1       misaligned, illegal size, or out of range; valid with resp_valid
//  mem_addr     out  ADDR_W  word index = req_addr[ADDR_W+1:2]
//  mem_rd       out  1       read strobe
//  mem_wr       out  1       write strobe (memory writes on posedge)
//  mem_wdata    out  32      full word to write
//  mem_rdata    in   32      combinational read data for mem_addr
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0,
//    latched addr/data=0. Memory strobes are 0 whenever not IDLE-accept or MERGE.
//    Reset during MERGE abandons the RMW: no write, no response.
//  - Accept = req_valid & req_ready. Memory strobes are combinational in the accept cycle.
//  - Error check at accept: half needs addr[0]=0; word needs addr[1:0]=0; size 11;
//    word index >= DEPTH_WORDS. On error: no strobe; next cycle resp_valid=1, resp_err=1,
//    resp_rdata=0.
//  - Load (IDLE): mem_rd=1. Capture and extend mem_rdata lane at the posedge.
//    Next cycle: resp_valid=1. Latency 1; back-to-back loads every cycle.
//    Byte lane = [31-8*o -: 8] with o=addr[1:0]. Half = addr[1] ? [15:0] : [31:16].
//    Sign-extend unless req_uns.
//  - SW (IDLE): mem_wr=1, mem_wdata=req_wdata. Next cycle: resp_valid=1. Latency 1.
//  - SB/SH (IDLE): mem_rd=1. Latch old word, addr, size, wdata. Go to MERGE (req_ready=0).
//  - MERGE: mem_addr=latched word index, mem_wr=1, mem_wdata=old word with the addressed
//    lane replaced by wdata[7:0] or [15:0]. Next state IDLE; resp_valid=1 in the next cycle.
//    Store latency 2; throughput 1 per 2 cycles.
//  - FSM: IDLE -(accept SB/SH, no error)-> MERGE -> IDLE. All else stays in IDLE.
//  - resp_valid is a pulse with no backpressure; the consumer must take it that cycle.
//  - A request presented while req_ready=0 is ignored; the requester holds it.
// TESTING
//  1 Reset: hold rst_n=0 for 3 cycles mid-MERGE -> no mem_wr; all resp_* = 0; req_ready=1.
//  2 SW 0xDEADBEEF @0x10, then LW @0x10 -> mem_wr pulse, addr=4; LW resp_rdata=0xDEADBEEF.
//  3 Word 0x11223344 @0x20; SB 0xAA @0x22 -> MERGE writes 0x1122AA44; resp 2 cycles later.
//  4 Word 0x80FF7F01 @0x30; LB @0x31 -> 0xFFFFFFFF; LBU @0x31 -> 0x000000FF;
//    LH @0x30 -> 0xFFFF80FF; LHU @0x32 -> 0x00007F01.
//  5 LW @0x13 / SH @0x11 / size=11 / LW @0x200 (index 128) -> resp_err=1; mem untouched.
//  6 SH 0xBEEF @0x22 with req_valid held, then LW @0x20 queued behind it ->
//    req_ready low 1 cycle; LW accepted next; LW sees merged word 0x1122BEEF.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request, response and data-memory port bundle for the load/store unit.
// master = requester/memory side, slave = the load/store unit itself.
interface load_store_unit_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_uns;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output req_valid, req_we, req_size, req_uns, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_uns, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit in front of a word-wide, big-endian data memory.
// Loads and word stores complete in one cycle; byte/half stores run a
// read-modify-write through the MERGE state because the memory only writes words.
module load_store_unit #(
    parameter int ADDR_W      = 16,
    parameter int DEPTH_WORDS = 128
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    load_store_unit_if.slave   i_bus
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_MERGE = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    logic [0:0]        r_state;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_off;
    logic [1:0]        r_size;
    logic [15:0]       r_wdata;
    logic [31:0]       r_old;

    logic              w_idle;
    logic              w_accept;
    logic              w_err;
    logic              w_ok;
    logic              w_word_store;
    logic [31:0]       w_merged;

    // Select the addressed lane (offset 0 = MSB byte) and extend it to 32 bits.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [1:0]  size,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            SZ_BYTE: res = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: res = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed byte or half of the old word with the store data.
    function automatic logic [31:0] merge_store(input logic [31:0] old,
                                                input logic [1:0]  off,
                                                input logic [1:0]  size,
                                                input logic [15:0] wd);
        logic [31:0] res;
        res = old;
        if (size == SZ_BYTE) begin
            case (off)
                2'd0:    res[31:24] = wd[7:0];
                2'd1:    res[23:16] = wd[7:0];
                2'd2:    res[15:8]  = wd[7:0];
                default: res[7:0]   = wd[7:0];
            endcase
        end else if (off[1]) begin
            res[15:0] = wd;
        end else begin
            res[31:16] = wd;
        end
        return res;
    endfunction

    // Accept qualification and request checks (alignment, size, range).
    always_comb begin
        w_idle       = (r_state == S_IDLE);
        w_accept     = i_bus.req_valid & w_idle;
        w_err        = (i_bus.req_size == SZ_ILL)
                     | ((i_bus.req_size == SZ_HALF) & i_bus.req_addr[0])
                     | ((i_bus.req_size == SZ_WORD) & (i_bus.req_addr[1:0] != 2'b00))
                     | ({2'b00, i_bus.req_addr[31:2]} >= 32'(DEPTH_WORDS));
        w_ok         = w_accept & ~w_err;
        w_word_store = i_bus.req_we & (i_bus.req_size == SZ_WORD);
        w_merged     = merge_store(r_old, r_off, r_size, r_wdata);
    end

    // Memory port drive; strobes are forced off while reset is asserted so a
    // reset landing on the MERGE cycle abandons the write.
    always_comb begin
        i_bus.req_ready = w_idle;
        i_bus.mem_addr  = w_idle ? i_bus.req_addr[ADDR_W+1:2] : r_addr;
        i_bus.mem_rd    = i_rst_n & w_ok & ~w_word_store;
        i_bus.mem_wr    = i_rst_n & ((w_ok & w_word_store) | ~w_idle);
        i_bus.mem_wdata = w_idle ? i_bus.req_wdata : w_merged;
        i_bus.resp_valid = r_resp_valid;
        i_bus.resp_err   = r_resp_err;
        i_bus.resp_rdata = r_resp_rdata;
    end

    // Control FSM, RMW context capture and one-cycle response pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_addr       <= '0;
            r_off        <= 2'b00;
            r_size       <= 2'b00;
            r_wdata      <= 16'h0;
            r_old        <= 32'h0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_err) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else if (!i_bus.req_we) begin
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= extract_load(i_bus.mem_rdata, i_bus.req_addr[1:0],
                                                         i_bus.req_size, i_bus.req_uns);
                        end else if (w_word_store) begin
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_state <= S_MERGE;
                            r_addr  <= i_bus.req_addr[ADDR_W+1:2];
                            r_off   <= i_bus.req_addr[1:0];
                            r_size  <= i_bus.req_size;
                            r_wdata <= i_bus.req_wdata[15:0];
                            r_old   <= i_bus.mem_rdata;
                        end
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b1;
                end
            endcase
        end
    end

endmodule
